// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: rotation mode (sin/cos, vector rotate) and vectoring mode
// (magnitude/atan2) with quadrant pre-rotation and valid/ready handshakes.
module cordic_iter #(
    parameter int INTEGER_WIDTH        = 4,
    parameter int FRACTIONAL_WIDTH     = 20,
    parameter int CORDIC_DATA_WIDTH    = INTEGER_WIDTH + FRACTIONAL_WIDTH,
    parameter int ITERATIONS           = 16,
    parameter int CORDIC_COUNTER_WIDTH = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                mode,
    input  logic signed [CORDIC_DATA_WIDTH-1:0] x_in,
    input  logic signed [CORDIC_DATA_WIDTH-1:0] y_in,
    input  logic signed [CORDIC_DATA_WIDTH-1:0] z_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [CORDIC_DATA_WIDTH-1:0] x_out,
    output logic signed [CORDIC_DATA_WIDTH-1:0] y_out,
    output logic signed [CORDIC_DATA_WIDTH-1:0] z_out,
    output logic                                busy
);

    localparam int W         = CORDIC_DATA_WIDTH;
    localparam int CW        = CORDIC_COUNTER_WIDTH;
    localparam int ROM_DEPTH = 2 ** CW;
    localparam int PREC      = 64;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ITERATE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    // atan(1/n) in Q(PREC) from its alternating Taylor series, evaluated at elaboration.
    function automatic logic [127:0] atan_recip_q(input logic [127:0] n);
        logic [127:0] one;
        logic [127:0] acc;
        logic [127:0] pw;
        logic         neg;
        one = 128'd1 << PREC;
        acc = '0;
        pw  = n;
        neg = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pw <= one) begin
                if (neg) acc = acc - one / (pw * 128'(2 * k + 1));
                else     acc = acc + one / (pw * 128'(2 * k + 1));
                pw  = pw * n * n;
                neg = ~neg;
            end
        end
        return acc;
    endfunction

    // Past i=21 the cubic term is below one Q64 LSB, so atan(2^-i) is just 2^-i.
    function automatic logic [127:0] atan_q(input int i);
        if (i == 0)         return atan_recip_q(128'd2) + atan_recip_q(128'd3);
        else if (i < 22)    return atan_recip_q(128'd1 << i);
        else if (i < PREC)  return 128'd1 << (PREC - i);
        else                return '0;
    endfunction

    function automatic logic [W-1:0] to_fixed(input logic [127:0] q);
        return W'((q + (128'd1 << (PREC - FRACTIONAL_WIDTH - 1))) >> (PREC - FRACTIONAL_WIDTH));
    endfunction

    localparam logic signed [W-1:0] HALF_PI = to_fixed(atan_q(0) << 1);

    logic signed [W-1:0] atan_rom [ROM_DEPTH];

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_atan
        localparam logic [W-1:0] ENTRY = (g < ITERATIONS) ? to_fixed(atan_q(g)) : '0;
        assign atan_rom[g] = ENTRY;
    end

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic                mode_q;
    logic signed [W-1:0] x_r;
    logic signed [W-1:0] y_r;
    logic signed [W-1:0] z_r;

    logic signed [W-1:0] pre_x;
    logic signed [W-1:0] pre_y;
    logic signed [W-1:0] pre_z;
    logic                dir_pos;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] x_next;
    logic signed [W-1:0] y_next;
    logic signed [W-1:0] z_next;

    assign in_ready = !rst && clk_en && (state == ST_IDLE);
    assign busy     = !rst && (state != ST_IDLE);

    // Fold the operand into the right half-plane so the micro-rotations can converge.
    always_comb begin
        pre_x = x_in;
        pre_y = y_in;
        pre_z = z_in;
        if (!mode) begin
            if (z_in > HALF_PI) begin
                pre_x = -y_in;
                pre_y = x_in;
                pre_z = z_in - HALF_PI;
            end else if (z_in < -HALF_PI) begin
                pre_x = y_in;
                pre_y = -x_in;
                pre_z = z_in + HALF_PI;
            end
        end else if (x_in[W-1]) begin
            if (!y_in[W-1]) begin
                pre_x = y_in;
                pre_y = -x_in;
                pre_z = z_in + HALF_PI;
            end else begin
                pre_x = -y_in;
                pre_y = x_in;
                pre_z = z_in - HALF_PI;
            end
        end
    end

    assign dir_pos = mode_q ? y_r[W-1] : ~z_r[W-1];
    assign x_sh    = x_r >>> cnt;
    assign y_sh    = y_r >>> cnt;
    assign x_next  = dir_pos ? x_r - y_sh : x_r + y_sh;
    assign y_next  = dir_pos ? y_r + x_sh : y_r - x_sh;
    assign z_next  = dir_pos ? z_r - atan_rom[cnt] : z_r + atan_rom[cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        x_r    <= pre_x;
                        y_r    <= pre_y;
                        z_r    <= pre_z;
                        cnt    <= '0;
                        state  <= ST_ITERATE;
                    end
                end
                ST_ITERATE: begin
                    x_r <= x_next;
                    y_r <= y_next;
                    z_r <= z_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        x_out     <= x_next;
                        y_out     <= y_next;
                        z_out     <= z_next;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter: directed rotation/vectoring vectors, backpressure,
// clock-enable gating and reset in the middle of an operation.
module tb_cordic_iter;

    localparam int W   = 24;
    localparam int N   = 16;
    localparam int TOL = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [W-1:0] z_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic [W-1:0] z_out;
    logic         busy;

    int tests = 0;
    int fails = 0;

    string name_q[$];
    int    ex_q[$];
    int    ey_q[$];
    int    ez_q[$];

    cordic_iter #(
        .INTEGER_WIDTH(4),
        .FRACTIONAL_WIDTH(20),
        .ITERATIONS(N),
        .CORDIC_COUNTER_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode),
        .x_in(x_in),
        .y_in(y_in),
        .z_in(z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out(x_out),
        .y_out(y_out),
        .z_out(z_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic void checkOutput(input string name, input int actual, input int expected, input int tol);
        int diff;
        tests++;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tolerance %0d)", name, actual, expected, tol);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake pops one expectation and compares it.
    always @(negedge clk) begin
        if (!rst && clk_en && out_valid && out_ready) begin
            if (name_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_output: got x=%0d y=%0d z=%0d, expected no output", sx(x_out), sx(y_out), sx(z_out));
            end else begin
                string n;
                n = name_q.pop_front();
                checkOutput({n, "_x"}, sx(x_out), ex_q.pop_front(), TOL);
                checkOutput({n, "_y"}, sx(y_out), ey_q.pop_front(), TOL);
                checkOutput({n, "_z"}, sx(z_out), ez_q.pop_front(), TOL);
            end
        end
    end

    task automatic applyStimulus(input string name, input logic m, input int xi, input int yi, input int zi,
                                 input int ex, input int ey, input int ez,
                                 input int gate_at, input int gate_len, input int hold_cycles);
        int           edges;
        bit           leak;
        bit           moved;
        logic [W-1:0] hx;
        logic [W-1:0] hy;
        logic [W-1:0] hz;
        name_q.push_back(name);
        ex_q.push_back(ex);
        ey_q.push_back(ey);
        ez_q.push_back(ez);
        mode      = m;
        x_in      = W'(xi);
        y_in      = W'(yi);
        z_in      = W'(zi);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        edges = 0;
        while (!in_ready && edges < 50) begin
            step();
            edges++;
        end
        checkOutput({name, "_accept_ready"}, int'(in_ready), 1, 0);
        step();
        // Operands change and in_valid stays high while iterating; none of it may be taken.
        mode = ~m;
        x_in = W'(123457);
        y_in = W'(-98765);
        z_in = W'(55555);
        edges = 0;
        leak  = 1'b0;
        while (!out_valid && edges < 200) begin
            if (edges == gate_at + gate_len) clk_en = 1'b1;
            else if (edges == gate_at) clk_en = 1'b0;
            if (in_ready || !busy) leak = 1'b1;
            step();
            edges++;
        end
        clk_en   = 1'b1;
        in_valid = 1'b0;
        checkOutput({name, "_latency"}, edges, N + gate_len, 0);
        checkOutput({name, "_ready_leak_while_busy"}, int'(leak), 0, 0);
        hx = x_out;
        hy = y_out;
        hz = z_out;
        moved = 1'b0;
        repeat (hold_cycles) begin
            step();
            if (x_out !== hx || y_out !== hy || z_out !== hz || !out_valid || in_ready || !busy) moved = 1'b1;
        end
        if (hold_cycles > 0) checkOutput({name, "_hold_stable"}, int'(moved), 0, 0);
        out_ready = 1'b1;
        step();
        checkOutput({name, "_valid_cleared"}, int'(out_valid), 0, 0);
        checkOutput({name, "_ready_after_done"}, int'(in_ready), 1, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  edges;
        bit  pulsed;
        rst       = 1'b1;
        clk_en    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        repeat (3) step();
        checkOutput("reset_out_valid", int'(out_valid), 0, 0);
        checkOutput("reset_x_out", sx(x_out), 0, 0);
        checkOutput("reset_in_ready", int'(in_ready), 0, 0);
        checkOutput("reset_busy", int'(busy), 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", int'(in_ready), 1, 0);
        checkOutput("idle_busy", int'(busy), 0, 0);
        clk_en = 1'b0;
        #1;
        checkOutput("idle_clk_en_low_in_ready", int'(in_ready), 0, 0);
        clk_en = 1'b1;
        #1;

        applyStimulus("sincos_pi6",    1'b0,  636751,       0,   549033,   908093,  524288,        0, 0, 0, 0);
        applyStimulus("rot_pi",        1'b0,  636751,       0,  3294199, -1048576,       0,        0, 0, 0, 0);
        applyStimulus("rot_half_pi",   1'b0,  636751,       0,  1647099,        0, 1048576,        0, 0, 0, 0);
        applyStimulus("rot_neg_pi",    1'b0,  636751,       0, -3294199, -1048576,       0,        0, 0, 0, 0);
        applyStimulus("vec_q1_hold",   1'b1,  524288,  524288,        0,  1220995,       0,   823550, 0, 0, 10);
        applyStimulus("vec_q2",        1'b1, -524288,  524288,        0,  1220995,       0,  2470649, 0, 0, 0);
        applyStimulus("vec_q3",        1'b1, -524288, -524288,        0,  1220995,       0, -2470649, 0, 0, 0);
        applyStimulus("vec_q1_gated",  1'b1,  524288,  524288,        0,  1220995,       0,   823550, 7, 5, 0);

        // Abort an operation at iteration 7; it must vanish without producing output.
        mode     = 1'b0;
        x_in     = W'(636751);
        y_in     = W'(0);
        z_in     = W'(549033);
        in_valid = 1'b1;
        edges = 0;
        while (!in_ready && edges < 50) begin
            step();
            edges++;
        end
        checkOutput("abort_accept_ready", int'(in_ready), 1, 0);
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        checkOutput("abort_out_valid", int'(out_valid), 0, 0);
        checkOutput("abort_x_out", sx(x_out), 0, 0);
        checkOutput("abort_y_out", sx(y_out), 0, 0);
        checkOutput("abort_z_out", sx(z_out), 0, 0);
        checkOutput("abort_in_ready_in_reset", int'(in_ready), 0, 0);
        checkOutput("abort_busy_in_reset", int'(busy), 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("abort_idle_in_ready", int'(in_ready), 1, 0);
        checkOutput("abort_idle_busy", int'(busy), 0, 0);
        out_ready = 1'b1;
        pulsed = 1'b0;
        repeat (N + 8) begin
            step();
            if (out_valid) pulsed = 1'b1;
        end
        checkOutput("abort_no_late_valid", int'(pulsed), 0, 0);
        out_ready = 1'b0;

        applyStimulus("sincos_after_reset", 1'b0, 636751, 0, 549033, 908093, 524288, 0, 0, 0, 0);

        repeat (2) step();
        checkOutput("scoreboard_drained", name_q.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cordic_iter.md
Name: cordic_iter

Overview:
Parametrised iterative CORDIC engine in signed fixed point. It is the successor to the team's 8-step sine/cosine CORDIC. It supports rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude/atan2), with full-circle quadrant pre-rotation and valid/ready handshakes on both sides. Float↔fixed conversion stays outside the block, in the existing converter stages.

Parameters:
INTEGER_WIDTH, 4, integer bits including sign
FRACTIONAL_WIDTH, 20, fractional bits (F)
CORDIC_DATA_WIDTH, INTEGER_WIDTH+FRACTIONAL_WIDTH, width W of x/y/z datapath
ITERATIONS, 16, number of micro-rotations N (1..2**CORDIC_COUNTER_WIDTH-1)
CORDIC_COUNTER_WIDTH, 5, iteration counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clk_en  in  1  global enable; low freezes all state
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
mode  in  1  0 = rotation, 1 = vectoring; sampled on accept
x_in  in  W  signed x operand
y_in  in  W  signed y operand
z_in  in  W  signed angle (radians) / accumulator seed
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
x_out  out  W  signed x result (scaled by gain An)
y_out  out  W  signed y result (scaled by gain An)
z_out  out  W  signed angle result
busy  out  1  high in ITERATE or DONE

Behaviour:
- Reset: the rst edge forces state to IDLE, counter to 0, out_valid to 0, and x_out/y_out/z_out to 0. rst wins over clk_en and over any handshake. Reset mid-ITERATE or mid-DONE discards the operation with no output. in_ready and busy are 0 while rst is high.
- States:
  - IDLE: in_ready = clk_en. An accept is an edge with in_valid&&in_ready. On accept, latch mode, load x/y/z after pre-rotation, set counter i=0, go to ITERATE.
  - ITERATE: on each enabled edge, perform micro-rotation i, then i++. The edge performing i=N-1 registers results to x_out/y_out/z_out, sets out_valid=1 and goes to DONE.
  - DONE: outputs and out_valid held stable. An edge with out_ready=1 (and clk_en) clears out_valid and returns to IDLE. No new accept is allowed in the same cycle; back-to-back throughput is one op per N+2 cycles.
- Latency: out_valid rises N edges after the accept edge.
- clk_en low: no register changes in any state; in_ready=0; out_valid and outputs hold.
- Pre-rotation (applied on load, P = round(pi/2·2^F)):
  - rotation mode, z>P: x=-y, y=x, z=z-P
  - rotation mode, z<-P: x=y, y=-x, z=z+P
  - vectoring mode, x<0 and y>=0: x=y, y=-x, z=z+P
  - vectoring mode, x<0 and y<0: x=-y, y=x, z=z-P
  - otherwise the operands pass through unchanged.
  - Valid rotation input range is [-pi, pi]; z outside this range gives undefined results.
- Micro-rotation i:
  - Direction d: rotation mode d=+1 if z>=0, else -1. Vectoring mode d=+1 if y<0, else -1.
  - x'=x-d·(y>>>i); y'=y+d·(x>>>i); z'=z-d·atan_i.
  - >>> is an arithmetic shift with truncation.
  - All adds are two's complement modulo 2^W; there is no saturation.
- atan ROM: ITERATIONS entries, atan_i = round(atan(2^-i)·2^F). Entries that round to 0 stay 0.
- Gain: no internal compensation. The caller pre-scales by K=1/An (An≈1.646760 for N=16).
- Negation of the most negative value wraps; this is legal only at the out-of-range corner.

Test Plan:
- Rotation sin/cos, F=20, N=16: x_in=636751 (K), y_in=0, z_in=549033 (pi/6) → x_out≈908093, y_out≈524288, z_out≈0 (each within ±32 LSB); out_valid rises 16 edges after accept.
- Quadrant pre-rotation: x_in=636751, y_in=0, z_in=3294199 (pi) → x_out≈-1048576, y_out≈0 (±32 LSB).
- Vectoring: x_in=y_in=524288, z_in=0 → z_out≈823550 (pi/4), x_out≈1220995, y_out≈0 (±32 LSB). Repeat with x_in=-524288 → z_out≈2470649 (3pi/4).
- Handshake and backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; outputs must stay stable and in_ready=0.
  - Then pulse out_ready; in_ready must assert on the next cycle.
  - in_valid held high during ITERATE must not trigger a second accept.
- clk_en gating: drop clk_en for 5 cycles mid-ITERATE → out_valid is delayed by exactly 5 cycles, with results identical to the ungated run.
- Reset mid-op: assert rst at i=7 → next cycle state IDLE, out_valid=0, outputs 0, no out_valid pulse afterwards; a new op then completes correctly.
